// File: rtl/esp8266_send_frame_if.sv
// Framer bus: application request/status, UART transmitter handshake and UART receiver snoop.
// master = application/UART side, slave = framer.
interface esp8266_send_frame_if;
    logic        start;
    logic [12:0] value;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic        rx_int;
    logic [7:0]  rx_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    // Handshakes: start and rx_int are one-cycle strobes that are always
    // accepted (start only acts in IDLE). tx_wr is a one-cycle strobe issued
    // only while tx_busy=0; the next byte waits for tx_busy to rise and then
    // fall, and tx_data stays stable from tx_wr until tx_busy falls.
    modport master (
        output start, value, tx_busy, rx_int, rx_data,
        input  tx_data, tx_wr, busy, done, err, dbg_state
    );
    modport slave (
        input  start, value, tx_busy, rx_int, rx_data,
        output tx_data, tx_wr, busy, done, err, dbg_state
    );
endinterface

// File: rtl/esp8266_send_frame.sv
// ESP8266 AT+CIPSEND framer: sends a value clamped to 999 as three ASCII digits.
// Define ESP8266_SEND_RETRY_EN to resend the whole frame once after a timeout or ERROR.
module esp8266_send_frame #(
    parameter logic [7:0]           LINK_ID     = "0",
    parameter int                   TIMEOUT_W   = 21,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 21'd1_843_200
) (
    input logic clk,
    input logic rst,
    esp8266_send_frame_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, WAIT_PROMPT, PAYLOAD, WAIT_OK, FINISH} state_t;

    state_t               state_q, state_n;
    logic [1:0]           ph_q, ph_n;
    logic [3:0]           idx_q, idx_n;
    logic [3:0]           d2_q, d1_q, d0_q, d2_n, d1_n, d0_n;
    logic [7:0]           tx_data_q, tx_data_n;
    logic                 tx_wr_q, tx_wr_n, busy_q, busy_n, done_q, done_n, err_q, err_n;
    logic [2:0]           ok_idx_q, ok_idx_n, er_idx_q, er_idx_n, ok_step, er_step;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_n, tmo_inc;
    logic [9:0]           clamp_v;
    logic [6:0]           rem100;
    logic [7:0]           cur_byte;
    logic                 last_byte, ok_hit, er_hit, tmo_hit, fail;
`ifdef ESP8266_SEND_RETRY_EN
    logic                 retry_q, retry_n;
`endif

    function automatic logic [7:0] cmd_byte(input logic [3:0] i);
        case (i)
            4'd0:  cmd_byte = "A";
            4'd1:  cmd_byte = "T";
            4'd2:  cmd_byte = "+";
            4'd3:  cmd_byte = "C";
            4'd4:  cmd_byte = "I";
            4'd5:  cmd_byte = "P";
            4'd6:  cmd_byte = "S";
            4'd7:  cmd_byte = "E";
            4'd8:  cmd_byte = "N";
            4'd9:  cmd_byte = "D";
            4'd10: cmd_byte = "=";
            4'd11: cmd_byte = LINK_ID;
            4'd12: cmd_byte = ",";
            4'd13: cmd_byte = "5";
            4'd14: cmd_byte = 8'h0d;
            default: cmd_byte = 8'h0a;
        endcase
    endfunction

    function automatic logic [7:0] ok_char(input logic [2:0] i);
        case (i)
            3'd0: ok_char = "S";
            3'd1: ok_char = "E";
            3'd2: ok_char = "N";
            3'd3: ok_char = "D";
            3'd4: ok_char = " ";
            3'd5: ok_char = "O";
            default: ok_char = "K";
        endcase
    endfunction

    function automatic logic [7:0] er_char(input logic [2:0] i);
        case (i)
            3'd0: er_char = "E";
            3'd1: er_char = "R";
            3'd2: er_char = "R";
            3'd3: er_char = "O";
            default: er_char = "R";
        endcase
    endfunction

    // A mismatching byte may itself start a new match.
    function automatic logic [2:0] step(input logic [2:0] i, input logic [7:0] b,
                                        input logic [7:0] want, input logic [7:0] first);
        if (b == want)       step = i + 3'd1;
        else if (b == first) step = 3'd1;
        else                 step = 3'd0;
    endfunction

    always_comb begin
        state_n   = state_q;
        ph_n      = ph_q;
        idx_n     = idx_q;
        d2_n      = d2_q;
        d1_n      = d1_q;
        d0_n      = d0_q;
        tx_data_n = tx_data_q;
        tx_wr_n   = 1'b0;
        busy_n    = busy_q;
        done_n    = 1'b0;
        err_n     = 1'b0;
        ok_idx_n  = ok_idx_q;
        er_idx_n  = er_idx_q;
        tmo_n     = tmo_q;
        fail      = 1'b0;
`ifdef ESP8266_SEND_RETRY_EN
        retry_n   = retry_q;
`endif
        clamp_v   = (bus.value > 13'd999) ? 10'd999 : bus.value[9:0];
        rem100    = 7'(clamp_v % 10'd100);
        ok_step   = step(ok_idx_q, bus.rx_data, ok_char(ok_idx_q), "S");
        er_step   = step(er_idx_q, bus.rx_data, er_char(er_idx_q), "E");
        ok_hit    = bus.rx_int && (ok_step == 3'd7);
        er_hit    = bus.rx_int && (er_step == 3'd5);
        tmo_inc   = tmo_q + 1'b1;
        tmo_hit   = (tmo_inc == TIMEOUT_CYC);
        cur_byte  = cmd_byte(idx_q);
        last_byte = (idx_q == 4'd15);
        if (state_q == PAYLOAD) begin
            last_byte = (idx_q == 4'd4);
            case (idx_q)
                4'd0:    cur_byte = 8'h30 + {4'h0, d2_q};
                4'd1:    cur_byte = 8'h30 + {4'h0, d1_q};
                4'd2:    cur_byte = 8'h30 + {4'h0, d0_q};
                4'd3:    cur_byte = 8'h0d;
                default: cur_byte = 8'h0a;
            endcase
        end

        case (state_q)
            IDLE: begin
`ifdef ESP8266_SEND_RETRY_EN
                retry_n = 1'b0;
`endif
                if (bus.start) begin
                    d2_n    = 4'(clamp_v / 10'd100);
                    d1_n    = 4'(rem100 / 7'd10);
                    d0_n    = 4'(rem100 % 7'd10);
                    busy_n  = 1'b1;
                    idx_n   = 4'd0;
                    ph_n    = 2'd0;
                    state_n = CMD;
                end
            end
            CMD, PAYLOAD: begin
                // Phases: 0 issue byte, 1 wait for tx_busy high, 2 wait for tx_busy low.
                case (ph_q)
                    2'd0: if (!bus.tx_busy) begin
                        tx_wr_n   = 1'b1;
                        tx_data_n = cur_byte;
                        ph_n      = 2'd1;
                    end
                    2'd1: if (bus.tx_busy) ph_n = 2'd2;
                    default: if (!bus.tx_busy) begin
                        ph_n = 2'd0;
                        if (last_byte) begin
                            idx_n   = 4'd0;
                            state_n = (state_q == CMD) ? WAIT_PROMPT : WAIT_OK;
                        end else begin
                            idx_n = idx_q + 4'd1;
                        end
                    end
                endcase
            end
            WAIT_PROMPT: begin
                tmo_n = tmo_inc;
                if (bus.rx_int && bus.rx_data == ">") state_n = PAYLOAD;
                else if (er_hit || tmo_hit)           fail = 1'b1;
                else if (bus.rx_int)                  er_idx_n = er_step;
            end
            WAIT_OK: begin
                tmo_n = tmo_inc;
                if (ok_hit) begin
                    done_n  = 1'b1;
                    state_n = FINISH;
                end else if (er_hit || tmo_hit) begin
                    fail = 1'b1;
                end else if (bus.rx_int) begin
                    ok_idx_n = ok_step;
                    er_idx_n = er_step;
                end
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase

        if (fail) begin
`ifdef ESP8266_SEND_RETRY_EN
            if (!retry_q) begin
                retry_n = 1'b1;
                idx_n   = 4'd0;
                ph_n    = 2'd0;
                state_n = CMD;
            end else begin
                err_n   = 1'b1;
                state_n = FINISH;
            end
`else
            err_n   = 1'b1;
            state_n = FINISH;
`endif
        end

        if (state_n != state_q) begin
            ok_idx_n = 3'd0;
            er_idx_n = 3'd0;
            tmo_n    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ph_q      <= 2'd0;
            idx_q     <= 4'd0;
            d2_q      <= 4'd0;
            d1_q      <= 4'd0;
            d0_q      <= 4'd0;
            tx_data_q <= 8'd0;
            tx_wr_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ok_idx_q  <= 3'd0;
            er_idx_q  <= 3'd0;
            tmo_q     <= '0;
`ifdef ESP8266_SEND_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            ph_q      <= ph_n;
            idx_q     <= idx_n;
            d2_q      <= d2_n;
            d1_q      <= d1_n;
            d0_q      <= d0_n;
            tx_data_q <= tx_data_n;
            tx_wr_q   <= tx_wr_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            err_q     <= err_n;
            ok_idx_q  <= ok_idx_n;
            er_idx_q  <= er_idx_n;
            tmo_q     <= tmo_n;
`ifdef ESP8266_SEND_RETRY_EN
            retry_q   <= retry_n;
`endif
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_wr     = tx_wr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;
endmodule
